// File: rtl/oven_pkg.sv
// ----------------------------------------------------------------------------
// oven_pkg
// Shared types and helpers for the oven datapath blocks.
//   ovenState_t : controller state, 2-bit encoding (0 IDLE .. 3 DONE); this is
//                 the value presented on the controller's `state` port.
//   bcdDigit_t  : one packed BCD digit.
//   BCD_BLANK   : digit code the seven-segment path renders as a blank.
//   constToBcd  : elaboration-time integer -> 4-digit BCD (constants only).
// ----------------------------------------------------------------------------
package oven_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREHEAT = 2'd1,
      BAKE    = 2'd2,
      DONE    = 2'd3
   } ovenState_t;

   typedef logic [3:0] bcdDigit_t;

   localparam bcdDigit_t BCD_BLANK = 4'd11;

   // Used for reset constants only; the runtime path uses bin_to_bcd10.
   function automatic logic [15:0] constToBcd(input int value);
      return {4'((value / 1000) % 10), 4'((value / 100) % 10),
              4'((value / 10) % 10),   4'(value % 10)};
   endfunction

endpackage

// File: rtl/bake_controller_bin_to_bcd10.sv
// ----------------------------------------------------------------------------
// bin_to_bcd10
// Combinational 10-bit binary to 4-digit BCD converter (shift-add-3).
// The caller registers the result.
//   bin : input  [9:0]  binary value, 0..1023
//   bcd : output [15:0] thousands, hundreds, tens, units digits
// ----------------------------------------------------------------------------
module bin_to_bcd10
   import oven_pkg::*;
(
   input  logic [9:0]  bin,
   output logic [15:0] bcd
);

   logic [25:0] shiftReg;
   bcdDigit_t   digit;

   // Double-dabble: before every shift, any digit >= 5 gets +3 so the
   // shift carries correctly into the next decimal place.
   always_comb begin
      shiftReg = {16'd0, bin};
      digit    = 4'd0;
      for (int i = 0; i < 10; i++) begin
         for (int d = 0; d < 4; d++) begin
            digit = shiftReg[10 + 4*d +: 4];
            if (digit >= 4'd5) begin
               shiftReg[10 + 4*d +: 4] = digit + 4'd3;
            end else begin
               shiftReg[10 + 4*d +: 4] = digit;
            end
         end
         shiftReg = {shiftReg[24:0], 1'b0};
      end
      bcd = shiftReg[25:10];
   end

endmodule

// File: rtl/bake_controller.sv
// ----------------------------------------------------------------------------
// bake_controller
// Downstream stage of the oven top-level FSM: models preheat, runs the MM:SS
// cook countdown, drives the ready LED and reports temperature / remaining
// time as BCD for the seven-segment path. A 1 Hz tick is derived from clk.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   start       in   begin a bake (honoured only in IDLE)
//   abort       in   return to IDLE, clear the time counter (wins over start)
//   target_temp in   [9:0]  target in binary deg F, clamped on latch
//   cook_time   in   [15:0] BCD M1 M0 S1 S0, normalised on latch
//   temp_bcd    out  [15:0] current temperature, BCD (one cycle behind)
//   time_bcd    out  [15:0] remaining time, BCD MM:SS
//   state       out  [1:0]  0 IDLE, 1 PREHEAT, 2 BAKE, 3 DONE
//   heating     out  high in PREHEAT and BAKE
//   ready_led   out  high in BAKE
//   done        out  high in DONE
//
// Build option: BAKE_COOLDOWN_EN -- when defined the oven cools by COOL_STEP
// per tick in IDLE/DONE down to AMBIENT; otherwise the temperature snaps to
// AMBIENT on the edge entering IDLE or DONE.
// ----------------------------------------------------------------------------
module bake_controller
   import oven_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int AMBIENT   = 70,
   parameter int MAX_TEMP  = 550,
   parameter int HEAT_STEP = 25,
   parameter int COOL_STEP = 10
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [9:0]  target_temp,
   input  logic [15:0] cook_time,
   output logic [15:0] temp_bcd,
   output logic [15:0] time_bcd,
   output logic [1:0]  state,
   output logic        heating,
   output logic        ready_led,
   output logic        done
);

   localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [9:0]     AMB_T      = 10'(AMBIENT);
   localparam logic [9:0]     MAX_T      = 10'(MAX_TEMP);
   localparam logic [10:0]    HEAT_T     = 11'(HEAT_STEP);
   localparam logic [10:0]    COOL_T     = 11'(COOL_STEP);
   localparam logic [15:0]    AMB_BCD    = constToBcd(AMBIENT);

`ifdef BAKE_COOLDOWN_EN
   localparam bit COOL_EN = 1'b1;
`else
   localparam bit COOL_EN = 1'b0;
`endif

   ovenState_t    stateR, nextState;
   logic [PW-1:0] presc;
   logic          tick;
   logic [9:0]    curTemp, nextTemp;
   logic [9:0]    targetR, nextTarget;
   logic [15:0]   timeCnt, nextTime;
   logic [15:0]   tempBcdComb;

   function automatic logic [9:0] clampTarget(input logic [9:0] t);
      if (t < AMB_T) begin
         return AMB_T;
      end else if (t > MAX_T) begin
         return MAX_T;
      end else begin
         return t;
      end
   endfunction

   // Seconds tens above 5 means the seconds field is not a valid MM:SS value;
   // it is pulled to the largest legal seconds value, 59.
   function automatic logic [15:0] normTime(input logic [15:0] t);
      bcdDigit_t m1, m0, s1, s0;
      m1 = (t[15:12] > 4'd9) ? 4'd9 : t[15:12];
      m0 = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
      if (t[7:4] > 4'd5) begin
         s1 = 4'd5;
         s0 = 4'd9;
      end else begin
         s1 = t[7:4];
         s0 = (t[3:0] > 4'd9) ? 4'd9 : t[3:0];
      end
      return {m1, m0, s1, s0};
   endfunction

   // One-second BCD MM:SS decrement; SS 00 wraps to 59 and borrows a minute.
   function automatic logic [15:0] bcdDec(input logic [15:0] t);
      bcdDigit_t m1, m0, s1, s0;
      {m1, m0, s1, s0} = t;
      if (s0 != 4'd0) begin
         s0 = s0 - 4'd1;
      end else begin
         s0 = 4'd9;
         if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
         end else begin
            s1 = 4'd5;
            if (m0 != 4'd0) begin
               m0 = m0 - 4'd1;
            end else begin
               m0 = 4'd9;
               m1 = m1 - 4'd1;
            end
         end
      end
      return {m1, m0, s1, s0};
   endfunction

   function automatic logic [9:0] heatStep(input logic [9:0] cur, input logic [9:0] tgt);
      logic [10:0] sum;
      sum = {1'b0, cur} + HEAT_T;
      if (sum >= {1'b0, tgt}) begin
         return tgt;
      end else begin
         return sum[9:0];
      end
   endfunction

   function automatic logic [9:0] coolStep(input logic [9:0] cur);
      if ({1'b0, cur} >= ({1'b0, AMB_T} + COOL_T)) begin
         return cur - COOL_T[9:0];
      end else begin
         return AMB_T;
      end
   endfunction

   assign tick     = (presc == PRESC_LAST);
   assign state    = stateR;
   assign time_bcd = timeCnt;

   bin_to_bcd10 uTempBcd (
      .bin (curTemp),
      .bcd (tempBcdComb)
   );

   // Free-running 1 Hz prescaler; a bake start does not re-phase it.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= {PW{1'b0}};
      end else if (tick) begin
         presc <= {PW{1'b0}};
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Next-state and next-datapath decode.
   always_comb begin
      nextState  = stateR;
      nextTemp   = curTemp;
      nextTime   = timeCnt;
      nextTarget = targetR;
      case (stateR)
         IDLE: begin
            if (abort) begin
               nextState = IDLE;
            end else if (start && (cook_time != 16'h0000)) begin
               nextState  = PREHEAT;
               nextTarget = clampTarget(target_temp);
               nextTime   = normTime(cook_time);
            end else begin
               nextState = IDLE;
            end
         end
         PREHEAT: begin
            if (tick && !abort) begin
               nextTemp = heatStep(curTemp, targetR);
            end else begin
               nextTemp = curTemp;
            end
            // Compared against the registered temperature every cycle, so a
            // target already reached costs exactly one PREHEAT cycle.
            if (abort) begin
               nextState = IDLE;
            end else if (curTemp >= targetR) begin
               nextState = BAKE;
            end else begin
               nextState = PREHEAT;
            end
         end
         BAKE: begin
            nextTemp = targetR;
            if (abort) begin
               nextState = IDLE;
            end else if (tick) begin
               nextTime  = bcdDec(timeCnt);
               nextState = (nextTime == 16'h0000) ? DONE : BAKE;
            end else if (timeCnt == 16'h0000) begin
               nextState = DONE;
            end else begin
               nextState = BAKE;
            end
         end
         DONE: begin
            if (abort) begin
               nextState = IDLE;
            end else begin
               nextState = DONE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase

      nextTime = abort ? 16'h0000 : nextTime;

      if (COOL_EN) begin
         if (tick && ((stateR == IDLE) || (stateR == DONE))) begin
            nextTemp = coolStep(curTemp);
         end else begin
            nextTemp = nextTemp;
         end
      end else begin
         if ((nextState == IDLE) || (nextState == DONE)) begin
            nextTemp = AMB_T;
         end else begin
            nextTemp = nextTemp;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateR  <= IDLE;
         curTemp <= AMB_T;
         targetR <= AMB_T;
         timeCnt <= 16'h0000;
      end else begin
         stateR  <= nextState;
         curTemp <= nextTemp;
         targetR <= nextTarget;
         timeCnt <= nextTime;
      end
   end

   // Registered status outputs (decoded from the next state so they change on
   // the same edge as `state`) and the registered temperature conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         temp_bcd  <= AMB_BCD;
         heating   <= 1'b0;
         ready_led <= 1'b0;
         done      <= 1'b0;
      end else begin
         temp_bcd  <= tempBcdComb;
         heating   <= (nextState == PREHEAT) || (nextState == BAKE);
         ready_led <= (nextState == BAKE);
         done      <= (nextState == DONE);
      end
   end

endmodule

// File: tb/tb_bake_controller.sv
// ----------------------------------------------------------------------------
// tb_bake_controller
// Directed self-checking bench for bake_controller with CLK_HZ = 4 (one tick
// every 4 clocks). Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_bake_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [9:0]  target_temp;
   logic [15:0] cook_time;
   logic [15:0] temp_bcd;
   logic [15:0] time_bcd;
   logic [1:0]  state;
   logic        heating;
   logic        ready_led;
   logic        done;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] heatSeq [4] = '{16'h0095, 16'h0120, 16'h0145, 16'h0170};
   logic [15:0] timeSeq [3] = '{16'h0002, 16'h0001, 16'h0000};

   bake_controller #(.CLK_HZ(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .target_temp (target_temp),
      .cook_time   (cook_time),
      .temp_bcd    (temp_bcd),
      .time_bcd    (time_bcd),
      .state       (state),
      .heating     (heating),
      .ready_led   (ready_led),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits (bounded) for temp_bcd to move away from `old`; on timeout the
   // returned value still equals `old`, which the caller's check rejects.
   task automatic waitTempChange(input logic [15:0] old, output logic [15:0] now);
      int n = 0;
      now = temp_bcd;
      while ((now == old) && (n < 20)) begin
         @(negedge clk);
         now = temp_bcd;
         n++;
      end
   endtask

   task automatic waitTimeChange(input logic [15:0] old, output logic [15:0] now);
      int n = 0;
      now = time_bcd;
      while ((now == old) && (n < 20)) begin
         @(negedge clk);
         now = time_bcd;
         n++;
      end
   endtask

   task automatic waitStateIs(input logic [1:0] want, input int limit);
      int n = 0;
      while ((state !== want) && (n < limit)) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic startBake(input logic [9:0] tgt, input logic [15:0] ct);
      target_temp = tgt;
      cook_time   = ct;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic pulseAbort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      logic [15:0] prev;
      logic [15:0] now;

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      target_temp = 10'd0; cook_time = 16'h0000;
      cycles(3);
      rst = 1'b0;
      cycles(10);

      // 1. reset state
      checkEq("rst state",   32'(state),     32'd0);
      checkEq("rst temp",    32'(temp_bcd),  32'h0070);
      checkEq("rst time",    32'(time_bcd),  32'h0000);
      checkEq("rst ready",   32'(ready_led), 32'd0);
      checkEq("rst heating", 32'(heating),   32'd0);
      checkEq("rst done",    32'(done),      32'd0);

      // 2. full bake: 170 F, 3 s
      startBake(10'd170, 16'h0003);
      checkEq("t2 preheat state", 32'(state),     32'd1);
      checkEq("t2 heating",       32'(heating),   32'd1);
      checkEq("t2 ready off",     32'(ready_led), 32'd0);
      prev = 16'h0070;
      for (int k = 0; k < 4; k++) begin
         waitTempChange(prev, now);
         checkEq("t2 preheat temp", 32'(now), 32'(heatSeq[k]));
         prev = now;
      end
      waitStateIs(2'd2, 10);
      checkEq("t2 bake state", 32'(state),     32'd2);
      checkEq("t2 bake ready", 32'(ready_led), 32'd1);
      checkEq("t2 bake time",  32'(time_bcd),  32'h0003);
      prev = 16'h0003;
      for (int k = 0; k < 3; k++) begin
         waitTimeChange(prev, now);
         checkEq("t2 countdown", 32'(now), 32'(timeSeq[k]));
         prev = now;
      end
      checkEq("t2 done state", 32'(state),     32'd3);
      checkEq("t2 done flag",  32'(done),      32'd1);
      checkEq("t2 done ready", 32'(ready_led), 32'd0);
      checkEq("t2 done heat",  32'(heating),   32'd0);
      cycles(1);
`ifndef BAKE_COOLDOWN_EN
      checkEq("t2 done ambient", 32'(temp_bcd), 32'h0070);
`endif
      startBake(10'd170, 16'h0003);
      checkEq("t2 start in done", 32'(state), 32'd3);
      pulseAbort();
      checkEq("t2 abort from done", 32'(state), 32'd0);
      checkEq("t2 abort done clr",  32'(done),  32'd0);

      // 5b + 3. target below ambient clamps to 70: one PREHEAT cycle; minute borrow
      startBake(10'd30, 16'h0100);
      checkEq("t5 one preheat", 32'(state), 32'd1);
      cycles(1);
      checkEq("t5 bake next",   32'(state),     32'd2);
      checkEq("t5 ready",       32'(ready_led), 32'd1);
      checkEq("t5 clamp temp",  32'(temp_bcd),  32'h0070);
      checkEq("t3 latched",     32'(time_bcd),  32'h0100);
      waitTimeChange(16'h0100, now);
      checkEq("t3 borrow", 32'(now), 32'h0059);
      waitTimeChange(16'h0059, now);
      checkEq("t3 next sec", 32'(now), 32'h0058);

      // 4. abort mid-bake, then abort+start together in IDLE
      abort = 1'b1;
      @(negedge clk);
      checkEq("t4 abort state", 32'(state),     32'd0);
      checkEq("t4 abort ready", 32'(ready_led), 32'd0);
      checkEq("t4 abort time",  32'(time_bcd),  32'h0000);
      target_temp = 10'd200; cook_time = 16'h0003; start = 1'b1;
      @(negedge clk);
      checkEq("t4 abort wins", 32'(state), 32'd0);
      abort = 1'b0; start = 1'b0;
      cycles(1);

      // 5a. target above maximum clamps to 550
      startBake(10'd600, 16'h0002);
      waitStateIs(2'd2, 200);
      checkEq("t5 max state", 32'(state),    32'd2);
      checkEq("t5 max temp",  32'(temp_bcd), 32'h0550);
      pulseAbort();
      checkEq("t5 max abort", 32'(state), 32'd0);

      // 6. zero cook time ignored; seconds normalised; reset mid-preheat
      startBake(10'd200, 16'h0000);
      checkEq("t6 zero ignored", 32'(state),    32'd0);
      checkEq("t6 zero time",    32'(time_bcd), 32'h0000);
      startBake(10'd200, 16'h0075);
      checkEq("t6 norm state", 32'(state),    32'd1);
      checkEq("t6 norm time",  32'(time_bcd), 32'h0059);
      cycles(2);
      rst = 1'b1;
      @(negedge clk);
      checkEq("t6 rst state",   32'(state),     32'd0);
      checkEq("t6 rst temp",    32'(temp_bcd),  32'h0070);
      checkEq("t6 rst time",    32'(time_bcd),  32'h0000);
      checkEq("t6 rst heating", 32'(heating),   32'd0);
      checkEq("t6 rst ready",   32'(ready_led), 32'd0);
      checkEq("t6 rst done",    32'(done),      32'd0);

      // First tick lands CLK_HZ edges after reset release.
      rst = 1'b0;
      target_temp = 10'd200; cook_time = 16'h0005; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkEq("t6 restart state", 32'(state), 32'd1);
      cycles(3);
      checkEq("t6 before tick", 32'(temp_bcd), 32'h0070);
      cycles(1);
      checkEq("t6 first tick",  32'(temp_bcd), 32'h0095);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
